decode_stage: RTL
=================

# decode_stage

Registered RV32I instruction-decode stage with a two-entry skid buffer, placed between fetch and the ID/EX boundary in the pipelined core. It decodes opcode, register indices and immediate into a full control bundle and assigns a monotonically increasing retire-order tag. It exchanges instructions with fetch and execute over valid/ready handshakes and honours a pipeline flush.

## Interface
Parameters:
- PC_W, 32, width of instruction address
- ORDER_W, 64, width of the order tag

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- flush  in  1  discard all held and incoming instructions
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  stage can accept
- if_inst  in  32  instruction word
- if_pc  in  PC_W  instruction address
- id_valid  out  1  decoded bundle valid
- id_ready  in  1  execute accepts bundle
- id_pc  out  PC_W  passthrough PC
- id_rd, id_rs1, id_rs2  out  5 each  register indices (inst[11:7], [19:15], [24:20])
- id_imm  out  32  sign-extended immediate, per format
- id_regwrite, id_memwrite, id_memread, id_wb_src, id_alu_select, id_branch, id_jump  out  1 each  control
- id_ext  out  2  writeback-extension select
- id_muldiv  out  1  M-extension operation
- id_illegal  out  1  unrecognised encoding
- id_order  out  ORDER_W  retire-order tag

## Operation
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011 (OP requires funct7 0000000 or 0100000).
- regwrite: LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR, forced 0 when rd==0.
- memwrite: STORE. memread: LOAD. wb_src: LOAD or STORE.
- ext: LUI 11, AUIPC 01, JAL/JALR 10, else 00.
- alu_select 0 for OP and BRANCH, else 1. branch: BRANCH. jump: JAL/JALR.
- Immediate: I (OP-IMM, LOAD, JALR), S, B, U, J formats; R-type 0.
- Illegal: id_illegal=1; regwrite, memwrite, memread, branch, jump forced 0; bundle still flows and consumes an order tag.
- Order counter: starts 0, tag = counter at acceptance, +1 per accepted instruction, wraps modulo 2^ORDER_W; not rewound by flush.
- Buffer: main entry drives id_*; skid entry captures when main is full and not draining. if_ready = !skid_valid (registered, no combinational path from id_ready).
- Accept when if_valid && if_ready && !flush. Drain main when id_valid && id_ready; skid moves into main same cycle.
- flush: both entries cleared next edge; instruction offered in flush cycle dropped, counter not incremented; id_valid 0 next cycle.

## Timing
- Reset: id_valid 0, if_ready 1, all id_* 0, counter 0; asynchronous assert, synchronous-release deassert.
- Latency: accepted instruction appears on id_* one cycle later when empty.
- Throughput 1/cycle with id_ready held high.
- id_* stable while id_valid && !id_ready.
- Simultaneous drain and accept with both entries full impossible (if_ready low); with main full, skid empty: drain+accept keeps main full, skid empty.
- Reset mid-transfer discards both entries.

## Configuration
- RV32M_EN defined: OP with funct7 0000001 legal, id_muldiv=1, regwrite per rd rule, alu_select 0.
- Undefined: that encoding is illegal; id_muldiv tied 0.

## Test plan
- 0x00500093 (addi x1,x0,5), id_ready=1 -> next cycle id_valid=1, rd=1, imm=5, regwrite=1, alu_select=1, order=0.
- 0x12345137 (lui x2) then 0x0020A423 (sw x2,8(x1)) -> imm=0x12345000, ext=11, order=0; then memwrite=1, wb_src=1, regwrite=0, imm=8, order=1.
- id_ready=0, offer 3 instructions -> 2 accepted, if_ready=0 from cycle 2; release id_ready -> emitted in order, tags 0,1, then third tag 2.
- Both entries full, flush with if_valid=1 -> id_valid=0 next cycle, if_ready=1, next accepted tag continues (2).
- 0x022081B3 (mul x3,x1,x2) -> with RV32M_EN: muldiv=1, regwrite=1, illegal=0; without: illegal=1, regwrite=0.
- 0xFFFFFFFF -> illegal=1, all enables 0, tag consumed.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage with a two-entry skid buffer; optional M extension via RV32M_EN.
// Latency 1 cycle to id_*; 1 instr/cycle when id_ready is held. Backpressure: if_ready = !skid_valid (registered).
module decode_stage #(
    parameter int PC_W    = 32,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [31:0]        if_inst,
    input  logic [PC_W-1:0]    if_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [PC_W-1:0]    id_pc,
    output logic [4:0]         id_rd,
    output logic [4:0]         id_rs1,
    output logic [4:0]         id_rs2,
    output logic [31:0]        id_imm,
    output logic               id_regwrite,
    output logic               id_memwrite,
    output logic               id_memread,
    output logic               id_wb_src,
    output logic               id_alu_select,
    output logic               id_branch,
    output logic               id_jump,
    output logic [1:0]         id_ext,
    output logic               id_muldiv,
    output logic               id_illegal,
    output logic [ORDER_W-1:0] id_order
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [31:0]        imm;
        logic               regwrite;
        logic               memwrite;
        logic               memread;
        logic               wb_src;
        logic               alu_select;
        logic               branch;
        logic               jump;
        logic [1:0]         ext;
        logic               muldiv;
        logic               illegal;
        logic [ORDER_W-1:0] order;
    } bundle_t;

    bundle_t            dec;
    bundle_t            main_q;
    bundle_t            skid_q;
    logic               main_vld;
    logic               skid_vld;
    logic [ORDER_W-1:0] order_cnt;
    logic               legal;
    logic               wr;
    logic               accept;
    logic               drain;

    wire [6:0] opcode = if_inst[6:0];
    wire [6:0] funct7 = if_inst[31:25];

    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        wr         = 1'b0;
        dec.pc     = if_pc;
        dec.rd     = if_inst[11:7];
        dec.rs1    = if_inst[19:15];
        dec.rs2    = if_inst[24:20];
        dec.order  = order_cnt;
        case (opcode)
            OPC_LUI: begin
                wr = 1'b1; dec.ext = 2'b11;
                dec.imm = {if_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                wr = 1'b1; dec.ext = 2'b01;
                dec.imm = {if_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                wr = 1'b1; dec.ext = 2'b10; dec.jump = 1'b1;
                dec.imm = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                wr = 1'b1; dec.ext = 2'b10; dec.jump = 1'b1;
                dec.imm = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                wr = 1'b1; dec.memread = 1'b1; dec.wb_src = 1'b1;
                dec.imm = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            OPC_STORE: begin
                dec.memwrite = 1'b1; dec.wb_src = 1'b1;
                dec.imm = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            end
            OPC_OPIMM: begin
                wr = 1'b1;
                dec.imm = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            OPC_OP: begin
                wr = 1'b1;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    legal = 1'b1;
`ifdef RV32M_EN
                end else if (funct7 == 7'b0000001) begin
                    legal = 1'b1;
                    dec.muldiv = 1'b1;
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        dec.alu_select = !(opcode == OPC_OP || opcode == OPC_BRANCH);
        dec.illegal    = !legal;
        // Illegal encodings still flow down the pipe, but must not touch any state.
        dec.regwrite   = wr && legal && (dec.rd != 5'd0);
        dec.memwrite   = dec.memwrite && legal;
        dec.memread    = dec.memread && legal;
        dec.branch     = dec.branch && legal;
        dec.jump       = dec.jump && legal;
    end

    assign if_ready = !skid_vld;
    assign accept   = if_valid && if_ready && !flush;
    assign drain    = main_vld && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
            order_cnt <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (accept)
                order_cnt <= order_cnt + ORDER_W'(1);
            // skid_vld implies main_vld, and accept implies !skid_vld.
            if (!main_vld || drain) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= accept;
                    if (accept)
                        main_q <= dec;
                end
            end else if (accept) begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
            end
        end
    end

    assign id_valid      = main_vld;
    assign id_pc         = main_q.pc;
    assign id_rd         = main_q.rd;
    assign id_rs1        = main_q.rs1;
    assign id_rs2        = main_q.rs2;
    assign id_imm        = main_q.imm;
    assign id_regwrite   = main_q.regwrite;
    assign id_memwrite   = main_q.memwrite;
    assign id_memread    = main_q.memread;
    assign id_wb_src     = main_q.wb_src;
    assign id_alu_select = main_q.alu_select;
    assign id_branch     = main_q.branch;
    assign id_jump       = main_q.jump;
    assign id_ext        = main_q.ext;
    assign id_muldiv     = main_q.muldiv;
    assign id_illegal    = main_q.illegal;
    assign id_order      = main_q.order;

endmodule
